// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_pkg
//  Description : Shared types and MISR constants for the exhaustive sweep
//                stimulus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR step: shift, fold the feedback polynomial, then inject the response.
    function automatic logic [15:0] misr_next(input logic [15:0] cur,
                                              input logic [15:0] din);
        return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ din;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_stim_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_stim_ctrl_if
//  Description : Control, netlist-drive and record bus of the sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sweep_stim_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_resp;
    logic             busy;
    logic             done;
    logic [15:0]      sig;

    modport master (
        input  start, abort, dut_out, rec_ready,
        output dut_in, rec_valid, rec_vec, rec_resp, busy, done, sig
    );

    modport slave (
        output start, abort, dut_out, rec_ready,
        input  dut_in, rec_valid, rec_vec, rec_resp, busy, done, sig
    );
endinterface
`default_nettype wire

// File: rtl/sweep_misr16.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_misr16
//  Description : 16-bit MISR (poly 0x1021, seed 0xFFFF) with clear and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_misr16
    import sweep_pkg::*;
(
    input  wire logic        CK,
    input  wire logic        reset,
    input  wire logic        clr_i,
    input  wire logic        en_i,
    input  wire logic [15:0] din_i,
    output logic      [15:0] sig_o
);

    logic [15:0] sig_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= MISR_SEED;
        end else if (clr_i) begin
            sig_q <= MISR_SEED;
        end else if (en_i) begin
            sig_q <= misr_next(sig_q, din_i);
        end
    end

    assign sig_o = sig_q;

endmodule
`default_nettype wire

// File: rtl/sweep_stim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_stim_ctrl
//  Description : Walks a netlist through all 2^N_IN input patterns, emits each
//                {vector,response} record and folds responses into a MISR.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_stim_ctrl
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input wire logic         CK,
    input wire logic         reset,
    sweep_stim_ctrl_if.master bus
);

    localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    // Index is one bit wider than the vector so the terminal compare never sees a wrap.
    localparam logic [N_IN:0]    IDX_LAST = {1'b0, {N_IN{1'b1}}};

    state_t           state_q;
    logic [N_IN:0]    idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_IN-1:0]  dut_in_q;
    logic [N_IN-1:0]  rec_vec_q;
    logic [N_OUT-1:0] rec_resp_q;
    logic             rec_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             misr_clr_d;
    logic             misr_en_d;
    logic [15:0]      misr_din_d;
    logic [15:0]      misr_sig;

    always_comb begin
        misr_clr_d              = (state_q == IDLE) && bus.start && !bus.abort;
        misr_en_d               = (state_q == EMIT) && rec_valid_q && bus.rec_ready && !bus.abort;
        misr_din_d              = '0;
        misr_din_d[N_OUT-1:0]   = rec_resp_q;
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            rec_vec_q   <= '0;
            rec_resp_q  <= '0;
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q != IDLE) && bus.abort) begin
                // Abort outranks everything; the MISR is left holding the partial signature.
                state_q     <= IDLE;
                rec_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                dut_in_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q <= APPLY;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                        end
                    end
                    APPLY: begin
                        dut_in_q <= idx_q[N_IN-1:0];
                        cnt_q    <= CNT_LOAD;
                        state_q  <= WAIT;
                    end
                    WAIT: begin
                        if (cnt_q == '0) begin
                            rec_resp_q  <= bus.dut_out;
                            rec_vec_q   <= idx_q[N_IN-1:0];
                            rec_valid_q <= 1'b1;
                            state_q     <= EMIT;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    EMIT: begin
                        if (rec_valid_q && bus.rec_ready) begin
                            rec_valid_q <= 1'b0;
                            if (idx_q == IDX_LAST) begin
                                state_q <= FIN;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= APPLY;
                            end
                        end
                    end
                    FIN: begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                        state_q  <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    sweep_misr16 u_misr (
        .CK    (CK),
        .reset (reset),
        .clr_i (misr_clr_d),
        .en_i  (misr_en_d),
        .din_i (misr_din_d),
        .sig_o (misr_sig)
    );

    assign bus.dut_in    = dut_in_q;
    assign bus.rec_valid = rec_valid_q;
    assign bus.rec_vec   = rec_vec_q;
    assign bus.rec_resp  = rec_resp_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sig       = misr_sig;

endmodule
`default_nettype wire
